// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: scan controller for an N-digit 7-segment display sharing one
// 5-bit-code segment decoder; double-buffered code registers, blanking gap per digit.
// Ports: clk, reset (sync, active-high), en, wr_en/wr_addr/wr_data (shadow write),
//   commit (shadow->active at next frame wrap), seg_code, dig_sel (active-low),
//   frame_done (1-cycle pulse after wrap), busy_commit (commit pending).
// Optional: define DISP_BLINK_EN to add blink_mask[N_DIGITS-1:0] and a blink phase
//   that toggles every BLINK_DIV frames; masked digits stay dark while phase=1.
module display_scan_ctrl #(
    parameter int N_DIGITS = 4,
    parameter int DIV      = 50000,
    parameter int BLANK    = 16,
`ifdef DISP_BLINK_EN
    parameter int BLINK_DIV = 25,
`endif
    localparam int AW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [4:0]          wr_data,
    input  logic                commit,
`ifdef DISP_BLINK_EN
    input  logic [N_DIGITS-1:0] blink_mask,
`endif
    output logic [4:0]          seg_code,
    output logic [N_DIGITS-1:0] dig_sel,
    output logic                frame_done,
    output logic                busy_commit
);

    localparam int CMAX = (DIV > BLANK) ? DIV : BLANK;
    localparam int CW   = $clog2(CMAX) + 1;

    typedef enum logic {S_BLANK, S_SHOW} state_t;

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic [AW-1:0]         idx_q;
    logic [4:0]            shadow_q [N_DIGITS];
    logic [4:0]            active_q [N_DIGITS];
    logic                  pend_q;
    logic                  frame_done_q;
    logic [4:0]            seg_q;
    logic [N_DIGITS-1:0]   dig_q;

    logic                  blank_end;
    logic                  show_end;
    logic                  last_dig;
    logic                  wrap;
    logic                  copy;
    logic                  wr_ok;
    logic [AW-1:0]         idx_nx;
    logic [4:0]            seg_nx;
    logic [N_DIGITS-1:0]   show_sel;

`ifdef DISP_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV) + 1;
    logic          phase_q;
    logic [BW-1:0] bcnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= 1'b0;
            bcnt_q  <= '0;
        end else if (wrap) begin
            if (bcnt_q == BW'(BLINK_DIV - 1)) begin
                bcnt_q  <= '0;
                phase_q <= ~phase_q;
            end else begin
                bcnt_q <= bcnt_q + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        blank_end = (state_q == S_BLANK) && (cnt_q == CW'(BLANK - 1));
        show_end  = (state_q == S_SHOW) && (cnt_q == CW'(DIV - 1));
        last_dig  = (idx_q == AW'(N_DIGITS - 1));
        wrap      = en && show_end && last_dig;
        copy      = wrap && pend_q;
        wr_ok     = int'(wr_addr) < N_DIGITS;
        idx_nx    = last_dig ? '0 : idx_q + 1'b1;
        // The first BLANK cycle after a wrap must already show the copied code.
        seg_nx    = copy ? shadow_q[idx_nx] : active_q[idx_nx];
        show_sel  = '1;
        show_sel[idx_q] = 1'b0;
`ifdef DISP_BLINK_EN
        if (phase_q && blink_mask[idx_q]) show_sel = '1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_DIGITS; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            pend_q       <= 1'b0;
            frame_done_q <= 1'b0;
            state_q      <= S_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            seg_q        <= '0;
            dig_q        <= '1;
        end else begin
            if (wr_en && wr_ok) shadow_q[wr_addr] <= wr_data;
            // Copy reads pre-edge shadow; a same-cycle write lands in shadow only.
            if (copy) begin
                for (int i = 0; i < N_DIGITS; i++) active_q[i] <= shadow_q[i];
            end
            // A commit seen in the wrap cycle survives the copy for the next frame.
            pend_q       <= copy ? commit : (pend_q | commit);
            frame_done_q <= wrap;
            if (!en) begin
                state_q <= S_BLANK;
                cnt_q   <= '0;
                idx_q   <= '0;
                dig_q   <= '1;
                seg_q   <= active_q[0];
            end else if (blank_end) begin
                state_q <= S_SHOW;
                cnt_q   <= '0;
                dig_q   <= show_sel;
            end else if (show_end) begin
                state_q <= S_BLANK;
                cnt_q   <= '0;
                idx_q   <= idx_nx;
                dig_q   <= '1;
                seg_q   <= seg_nx;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                if (state_q == S_SHOW) dig_q <= show_sel;
                else seg_q <= active_q[idx_q];
            end
        end
    end

    assign seg_code    = seg_q;
    assign dig_sel     = dig_q;
    assign frame_done  = frame_done_q;
    assign busy_commit = pend_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl: directed bench with a frame-arithmetic reference model for a
// 4-digit instance plus literal checks, and a 3-digit instance for out-of-range writes.
module tb_display_scan_ctrl;

    localparam int N  = 4;
    localparam int DV = 4;
    localparam int BL = 2;
    localparam int SL = BL + DV;
    localparam int FR = N * SL;
    localparam int BDIV = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 4-digit instance
    logic       reset = 1'b1, en = 1'b0, wr_en = 1'b0, commit = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [4:0] wr_data = '0;
    logic [4:0] seg;
    logic [3:0] dig;
    logic       fd, busy;
`ifdef DISP_BLINK_EN
    logic [3:0] mask = 4'b0010;
`endif

    // 3-digit instance
    logic       reset1 = 1'b1, en1 = 1'b0, wr_en1 = 1'b0, commit1 = 1'b0;
    logic [1:0] wr_addr1 = '0;
    logic [4:0] wr_data1 = '0;
    logic [4:0] seg1;
    logic [2:0] dig1;
    logic       fd1, busy1;
`ifdef DISP_BLINK_EN
    logic [2:0] mask1 = 3'b000;
`endif

    display_scan_ctrl #(
        .N_DIGITS(N),
        .DIV(DV),
`ifdef DISP_BLINK_EN
        .BLINK_DIV(BDIV),
`endif
        .BLANK(BL)
    ) u0 (
        .clk(clk),
        .reset(reset),
        .en(en),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .commit(commit),
`ifdef DISP_BLINK_EN
        .blink_mask(mask),
`endif
        .seg_code(seg),
        .dig_sel(dig),
        .frame_done(fd),
        .busy_commit(busy)
    );

    display_scan_ctrl #(
        .N_DIGITS(3),
        .DIV(2),
`ifdef DISP_BLINK_EN
        .BLINK_DIV(2),
`endif
        .BLANK(1)
    ) u1 (
        .clk(clk),
        .reset(reset1),
        .en(en1),
        .wr_en(wr_en1),
        .wr_addr(wr_addr1),
        .wr_data(wr_data1),
        .commit(commit1),
`ifdef DISP_BLINK_EN
        .blink_mask(mask1),
`endif
        .seg_code(seg1),
        .dig_sel(dig1),
        .frame_done(fd1),
        .busy_commit(busy1)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: t = cycles since scanning (re)started; everything derives from it.
    int         t = 0;
    int         nwraps = 0;
    logic [4:0] sh [N];
    logic [4:0] act [N];
    logic       pend = 1'b0;
    logic       wrap_e;
    bit         started = 0;

    always @(posedge clk) begin
        if (reset) begin
            t = 0;
            nwraps = 0;
            pend = 1'b0;
            for (int i = 0; i < N; i++) begin
                sh[i] = '0;
                act[i] = '0;
            end
        end else begin
            wrap_e = en && ((t % FR) == FR - 1);
            if (wrap_e) begin
                nwraps++;
                if (pend) begin
                    for (int i = 0; i < N; i++) act[i] = sh[i];
                    pend = commit;
                end else begin
                    pend = commit;
                end
            end else begin
                pend = pend | commit;
            end
            if (wr_en && int'(wr_addr) < N) sh[wr_addr] = wr_data;
            t = en ? t + 1 : 0;
        end
        started = 1;
    end

    always @(negedge clk) begin
        int p, d, w;
        logic [3:0] e_dig;
        if (started) begin
            p = t % FR;
            d = p / SL;
            w = p % SL;
            e_dig = 4'hF;
            if (w >= BL) begin
                e_dig[d] = 1'b0;
`ifdef DISP_BLINK_EN
                if (((nwraps / BDIV) % 2 == 1) && mask[d]) e_dig = 4'hF;
`endif
            end
            chk("m_dig", 32'(dig), 32'(e_dig));
            chk("m_seg", 32'(seg), 32'(act[d]));
            chk("m_fd", 32'(fd), 32'((p == 0 && t > 0) ? 1 : 0));
            chk("m_busy", 32'(busy), 32'(pend));
        end
    end

    logic [4:0] vals [4] = '{5'h01, 5'h02, 5'h03, 5'h11};

    task automatic lit(input int c);
        logic [3:0] e8, e32;
        e8 = 4'b1101;
        e32 = 4'b1101;
`ifdef DISP_BLINK_EN
        e32 = 4'b1111;
`endif
        case (c)
            0:   chk("l_dig_c0", 32'(dig), 32'hF);
            2:   chk("l_dig_c2", 32'(dig), 32'hE);
            6:   chk("l_busy_c6", 32'(busy), 32'h1);
            8:   chk("l_dig_c8", 32'(dig), 32'(e8));
            20:  begin
                chk("l_dig_c20", 32'(dig), 32'h7);
                chk("l_seg_c20", 32'(seg), 32'h00);
            end
            23:  chk("l_fd_c23", 32'(fd), 32'h0);
            24:  begin
                chk("l_fd_c24", 32'(fd), 32'h1);
                chk("l_seg_c24", 32'(seg), 32'h01);
                chk("l_busy_c24", 32'(busy), 32'h0);
            end
            25:  chk("l_fd_c25", 32'(fd), 32'h0);
            32:  chk("l_blink_c32", 32'(dig), 32'(e32));
            44:  chk("l_seg_c44", 32'(seg), 32'h11);
            48:  begin
                chk("l_seg_c48", 32'(seg), 32'h07);
                chk("l_busy_c48", 32'(busy), 32'h1);
            end
            62:  chk("l_seg_c62", 32'(seg), 32'h03);
            72:  chk("l_busy_c72", 32'(busy), 32'h0);
            86:  chk("l_seg_c86", 32'(seg), 32'h1F);
            88:  begin
                chk("l_dig_c88", 32'(dig), 32'hF);
                chk("l_busy_c88", 32'(busy), 32'h1);
            end
            94:  chk("l_dig_c94", 32'(dig), 32'hE);
            116: begin
                chk("l_fd_c116", 32'(fd), 32'h1);
                chk("l_seg_c116", 32'(seg), 32'h07);
                chk("l_busy_c116", 32'(busy), 32'h0);
            end
            124: chk("l_seg_c124", 32'(seg), 32'h15);
            default: ;
        endcase
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        en = 1'b1;
        for (int c = 0; c <= 130; c++) begin
            wr_en = 1'b0;
            commit = 1'b0;
            case (c)
                0, 1, 2, 3: begin
                    wr_en = 1'b1;
                    wr_addr = c[1:0];
                    wr_data = vals[c];
                end
                5:  commit = 1'b1;
                40: commit = 1'b1;
                41: begin
                    wr_en = 1'b1;
                    wr_addr = 2'd0;
                    wr_data = 5'h07;
                end
                47: begin
                    commit = 1'b1;
                    wr_en = 1'b1;
                    wr_addr = 2'd2;
                    wr_data = 5'h1F;
                end
                80: commit = 1'b1;
                81: begin
                    wr_en = 1'b1;
                    wr_addr = 2'd1;
                    wr_data = 5'h15;
                end
                87: en = 1'b0;
                89: commit = 1'b1;
                92: en = 1'b1;
                default: ;
            endcase
            lit(c);
            @(negedge clk);
        end
        wr_en = 1'b0;
        commit = 1'b0;

        // 3-digit instance: write to index 3 must be dropped
        reset1 = 1'b0;
        en1 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            wr_en1 = 1'b0;
            commit1 = 1'b0;
            if (c < 3) begin
                wr_en1 = 1'b1;
                wr_addr1 = c[1:0];
                wr_data1 = 5'(5 + c);
            end else if (c == 3) begin
                wr_en1 = 1'b1;
                wr_addr1 = 2'd3;
                wr_data1 = 5'h1F;
            end else begin
                commit1 = 1'b1;
            end
            @(negedge clk);
        end
        wr_en1 = 1'b0;
        commit1 = 1'b0;
        k = 5;
        while (fd1 !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("n3_fd_cycle", 32'(k), 32'd9);
        chk("n3_seg0", 32'(seg1), 32'h05);
        chk("n3_busy", 32'(busy1), 32'h0);
        repeat (3) @(negedge clk);
        chk("n3_seg1", 32'(seg1), 32'h06);
        repeat (3) @(negedge clk);
        chk("n3_seg2", 32'(seg1), 32'h07);
        @(negedge clk);
        chk("n3_dig2", 32'(dig1), 32'h3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
